// File: rtl/tick_div_pkg.sv
// Shared definitions for the programmable tick divider.
//   DEF_DIV  divisor every channel comes out of reset with
//   DIV_MIN  value a written divisor of zero is clamped to
//   ch_w()   channel-select width, never narrower than one bit
package tick_div_pkg;
  localparam int DEF_DIV = 2;
  localparam int DIV_MIN = 1;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/prog_tick_divider_if.sv
// Divisor write port (valid/ready).
//   wr_valid  request, wr_ready  accept (valid & ready)
//   wr_ch     target channel, wr_div  new divisor
//   wr_now    1: load immediately, 0: stage until the channel's next wrap
interface prog_tick_divider_if #(
  parameter int NCH = 4,
  parameter int W   = 16
) ();
  logic                                 wr_valid;
  logic                                 wr_ready;
  logic [tick_div_pkg::ch_w(NCH)-1:0]   wr_ch;
  logic [W-1:0]                         wr_div;
  logic                                 wr_now;

  modport master (output wr_valid, wr_ch, wr_div, wr_now, input wr_ready);
  modport slave  (input wr_valid, wr_ch, wr_div, wr_now, output wr_ready);
endinterface

// File: rtl/tick_div_channel.sv
// One divider channel: counter, active/staged divisor and registered outputs.
//   en      count enable          sync    restart at count 0, apply staged
//   wr_acc  write accepted here   wr_now  immediate (1) or staged (0)
//   wr_div  divisor, already clamped to >= 1
//   tick    1-cycle pulse on wrap sq      high for ceil(D/2) counts
//   pending staged divisor waiting for a wrap or sync
module tick_div_channel #(
  parameter int W           = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         sync,
  input  logic         wr_acc,
  input  logic         wr_now,
  input  logic [W-1:0] wr_div,
  output logic         tick,
  output logic         sq,
  output logic         pending
);
  logic [W-1:0] cnt, div_a, staged;
  logic         wrap;
  logic [W:0]   half;

  // div_a is never 0, so div_a-1 cannot underflow
  assign wrap = en && (cnt == div_a - W'(1));
  // one extra bit so D = 2^W-1 rounds up without overflow
  assign half = ({1'b0, div_a} + (W+1)'(1)) >> 1;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      div_a   <= W'(DEFAULT_DIV);
      staged  <= '0;
      pending <= 1'b0;
      tick    <= 1'b0;
      sq      <= 1'b0;
    end else begin
      tick <= wrap && !sync;
      sq   <= en && ({1'b0, cnt} < half);
      if (sync) begin
        cnt <= '0;
        // a write is only accepted while nothing is pending, so these are exclusive
        if (wr_acc && wr_now) begin
          div_a   <= wr_div;
          pending <= 1'b0;
        end else if (wr_acc) begin
          staged  <= wr_div;
          pending <= 1'b1;
        end else if (pending) begin
          div_a   <= staged;
          pending <= 1'b0;
        end
      end else if (wr_acc && wr_now) begin
        div_a   <= wr_div;
        cnt     <= '0;
        pending <= 1'b0;
      end else begin
        if (en) cnt <= wrap ? '0 : cnt + W'(1);
        if (wrap && pending) begin
          div_a   <= staged;
          pending <= 1'b0;
        end
        // staged write landing on a wrap waits for the following wrap
        if (wr_acc) begin
          staged  <= wr_div;
          pending <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/prog_tick_divider.sv
// Multi-channel programmable tick generator.
//   clk, reset  clock, synchronous active-high reset
//   en          per-channel count enable
//   sync        restart all channels at count 0
//   wr          divisor write port (slave)
//   tick, sq    per-channel pulse and square wave (registered)
//   pending     per-channel staged-divisor flag
module prog_tick_divider
  import tick_div_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int W           = 16,
  parameter int DEFAULT_DIV = DEF_DIV
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   en,
  input  logic             sync,
  prog_tick_divider_if.slave wr,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   sq,
  output logic [NCH-1:0]   pending
);
  localparam int CW = ch_w(NCH);

  logic [2**CW-1:0] pend_pad;
  logic [W-1:0]     div_in;

  // Unused channel codes read a zero pending bit: always ready, write dropped.
  always_comb begin
    pend_pad          = '0;
    pend_pad[NCH-1:0] = pending;
  end

  assign wr.wr_ready = ~pend_pad[wr.wr_ch];
  assign div_in      = (wr.wr_div == '0) ? W'(DIV_MIN) : wr.wr_div;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic acc;
    assign acc = wr.wr_valid && wr.wr_ready && (wr.wr_ch == CW'(i));

    tick_div_channel #(.W(W), .DEFAULT_DIV(DEFAULT_DIV)) u_ch (
      .clk     (clk),
      .reset   (reset),
      .en      (en[i]),
      .sync    (sync),
      .wr_acc  (acc),
      .wr_now  (wr.wr_now),
      .wr_div  (div_in),
      .tick    (tick[i]),
      .sq      (sq[i]),
      .pending (pending[i])
    );
  end
endmodule

// File: tb/tb_prog_tick_divider.sv
module tb_prog_tick_divider;
  localparam int NCH = 3;
  localparam int W   = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic [NCH-1:0] en;
  logic           sync;
  logic [NCH-1:0] tick, sq, pending;
  int checks = 0;
  int errors = 0;

  prog_tick_divider_if #(.NCH(NCH), .W(W)) wif ();

  prog_tick_divider #(.NCH(NCH), .W(W), .DEFAULT_DIV(2)) dut (
    .clk(clk), .reset(reset), .en(en), .sync(sync), .wr(wif),
    .tick(tick), .sq(sq), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_set(input int ch, input int dv, input logic now);
    wif.wr_valid = 1'b1;
    wif.wr_ch    = 2'(ch);
    wif.wr_div   = W'(dv);
    wif.wr_now   = now;
  endtask

  task automatic wr_idle();
    wif.wr_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; sync = 1'b0; en = '1; wr_idle();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    wif.wr_ch = 2'd0;
    #1;
    checks++; if (tick !== 3'b000) begin errors++; $display("FAIL reset_tick got=%b exp=000", tick); end
    checks++; if (sq !== 3'b000) begin errors++; $display("FAIL reset_sq got=%b exp=000", sq); end
    checks++; if (pending !== 3'b000) begin errors++; $display("FAIL reset_pending got=%b exp=000", pending); end
    checks++; if (wif.wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", wif.wr_ready); end
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++;
      if (tick !== ((k % 2 == 0) ? 3'b111 : 3'b000) || sq !== ((k % 2 == 1) ? 3'b111 : 3'b000))
        begin errors++; $display("FAIL default_div k=%0d tick=%b sq=%b", k, tick, sq); end
    end
  endtask

  task automatic test_immediate();
    do_reset();
    wr_set(1, 5, 1'b1);
    step();
    wr_idle();
    for (int k = 1; k <= 10; k++) begin
      step();
      checks++;
      if (tick[1] !== (k % 5 == 0) || sq[1] !== ((k - 1) % 5 < 3))
        begin errors++; $display("FAIL imm_ch1 k=%0d tick=%b sq=%b", k, tick[1], sq[1]); end
      checks++;
      if (tick[0] !== (k % 2 == 1) || sq[0] !== (k % 2 == 0))
        begin errors++; $display("FAIL imm_ch0 k=%0d tick=%b sq=%b", k, tick[0], sq[0]); end
    end
  endtask

  task automatic test_staged();
    do_reset();
    wr_set(0, 5, 1'b1);
    step();                                   // A: ch0 D=5, cnt=0
    wr_idle();
    step(); step();                           // A+2: cnt=2
    wr_set(0, 3, 1'b0);
    #1;
    checks++; if (wif.wr_ready !== 1'b1) begin errors++; $display("FAIL stage_ready_before got=%b exp=1", wif.wr_ready); end
    step();                                   // A+3: staged
    wr_set(0, 7, 1'b1);                       // must be refused while pending
    #1;
    checks++; if (pending[0] !== 1'b1) begin errors++; $display("FAIL stage_pending got=%b exp=1", pending[0]); end
    checks++; if (wif.wr_ready !== 1'b0) begin errors++; $display("FAIL stage_ready_busy got=%b exp=0", wif.wr_ready); end
    step();                                   // A+4
    wr_idle();
    checks++; if (pending[0] !== 1'b1 || tick[0] !== 1'b0) begin errors++; $display("FAIL stage_a4 pend=%b tick=%b exp 1/0", pending[0], tick[0]); end
    step();                                   // A+5: old period ends
    checks++; if (pending[0] !== 1'b0 || tick[0] !== 1'b1) begin errors++; $display("FAIL stage_apply pend=%b tick=%b exp 0/1", pending[0], tick[0]); end
    for (int k = 6; k <= 11; k++) begin
      step();
      checks++;
      if (tick[0] !== ((k - 5) % 3 == 0) || sq[0] !== ((k - 6) % 3 < 2))
        begin errors++; $display("FAIL stage_d3 k=%0d tick=%b sq=%b", k, tick[0], sq[0]); end
    end
  endtask

  task automatic test_sync();
    logic [2:0] et;
    do_reset();
    wr_set(0, 3, 1'b1); step();
    wr_set(2, 3, 1'b1); step();
    wr_set(2, 2, 1'b0); step();
    wr_idle();
    #1;
    checks++; if (pending !== 3'b100 || wif.wr_ready !== 1'b0) begin errors++; $display("FAIL sync_pre pend=%b ready=%b exp 100/0", pending, wif.wr_ready); end
    sync = 1'b1;
    wr_set(0, 4, 1'b0);                       // staged in the sync cycle
    step();
    sync = 1'b0;
    wr_idle();
    checks++; if (tick !== 3'b000 || pending !== 3'b001) begin errors++; $display("FAIL sync_edge tick=%b pend=%b exp 000/001", tick, pending); end
    for (int k = 1; k <= 8; k++) begin
      step();
      et = {(k % 2 == 0), (k % 2 == 0), (k == 3 || k == 7)};
      checks++;
      if (tick !== et) begin errors++; $display("FAIL sync_tick k=%0d got=%b exp=%b", k, tick, et); end
      checks++;
      if (pending !== ((k < 3) ? 3'b001 : 3'b000)) begin errors++; $display("FAIL sync_pend k=%0d got=%b", k, pending); end
    end
  endtask

  task automatic test_div_min_and_enable();
    logic [2:0] et [1:6];
    logic [2:0] es [1:6];
    et = '{3'b011, 3'b011, 3'b011, 3'b011, 3'b011, 3'b111};
    es = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b011, 3'b011};
    do_reset();
    wr_set(0, 0, 1'b1); step();
    wr_set(1, 1, 1'b1); step();
    wr_set(2, 5, 1'b1); step();
    wr_idle();
    for (int k = 1; k <= 2; k++) begin
      step();
      checks++;
      if (tick !== et[k] || sq !== es[k]) begin errors++; $display("FAIL dmin_run k=%0d tick=%b sq=%b", k, tick, sq); end
    end
    en = '0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (tick !== 3'b000 || sq !== 3'b000) begin errors++; $display("FAIL en_off k=%0d tick=%b sq=%b exp 000/000", k, tick, sq); end
    end
    en = '1;
    for (int k = 4; k <= 6; k++) begin
      step();
      checks++;
      if (tick !== et[k] || sq !== es[k]) begin errors++; $display("FAIL en_resume k=%0d tick=%b sq=%b exp %b/%b", k, tick, sq, et[k], es[k]); end
    end
  endtask

  task automatic test_out_of_range();
    do_reset();
    wr_set(3, 9, 1'b1);
    #1;
    checks++; if (wif.wr_ready !== 1'b1) begin errors++; $display("FAIL oor_ready got=%b exp=1", wif.wr_ready); end
    step();
    wr_idle();
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++;
      if (tick !== ((k % 2 == 1) ? 3'b111 : 3'b000) || pending !== 3'b000)
        begin errors++; $display("FAIL oor_drop k=%0d tick=%b pend=%b", k, tick, pending); end
    end
  endtask

  task automatic test_reset_pending();
    do_reset();
    wr_set(0, 7, 1'b1); step();
    wr_set(1, 4, 1'b0); step();               // lands on a ch1 wrap
    wr_idle();
    checks++; if (pending !== 3'b010 || tick[1] !== 1'b1) begin errors++; $display("FAIL rp_stage pend=%b tick1=%b exp 010/1", pending, tick[1]); end
    step();
    checks++; if (pending !== 3'b010) begin errors++; $display("FAIL rp_not_applied got=%b exp=010", pending); end
    reset = 1'b1;
    wif.wr_ch = 2'd1;
    step();
    reset = 1'b0;
    checks++; if (tick !== 3'b000 || sq !== 3'b000 || pending !== 3'b000 || wif.wr_ready !== 1'b1)
      begin errors++; $display("FAIL rp_reset tick=%b sq=%b pend=%b ready=%b", tick, sq, pending, wif.wr_ready); end
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++;
      if (tick !== ((k % 2 == 0) ? 3'b111 : 3'b000)) begin errors++; $display("FAIL rp_period k=%0d tick=%b", k, tick); end
    end
  endtask

  initial begin
    reset = 1'b1; en = '0; sync = 1'b0;
    wif.wr_valid = 1'b0; wif.wr_ch = '0; wif.wr_div = '0; wif.wr_now = 1'b0;
    test_reset();
    test_immediate();
    test_staged();
    test_sync();
    test_div_min_and_enable();
    test_out_of_range();
    test_reset_pending();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
